joybus_rx: RTL and testbench

Joybus line receiver for the GameCube/N64 controller path. It samples the open-drain data line, decodes each bit cell by its low-phase duration, and assembles bits MSB-first into bytes. It reports end of frame after the line has been idle for a set time. It sits on the line-side boundary, beside the injection transmitter, and feeds decoded console commands and controller reports to the injection control logic.

---
 rtl/jb_pkg.sv | 34 +++
 rtl/jb_sync.sv | 33 +++
 rtl/joybus_rx.sv | 209 ++++++++++++++++++++
 tb/tb_joybus_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_pkg.sv
// Shared Joybus definitions for the line receiver and the injection transmitter.
package jb_pkg;

  // Default timing at the nominal 50 MHz system clock
  localparam int JB_CLK_PER_US  = 50;
  localparam int JB_THRESH_CYC  = 2 * JB_CLK_PER_US;  // shorter low phase decodes as 1
  localparam int JB_GLITCH_CYC  = 5;                  // shorter low pulse is noise
  localparam int JB_LOW_MAX_CYC = 4 * JB_CLK_PER_US;  // longer low phase is a line fault
  localparam int JB_IDLE_CYC    = 5 * JB_CLK_PER_US;  // high time that closes a frame

  // Bit-cell durations in microseconds (a 4 us cell: 1/3 for a one, 3/1 for a zero)
  localparam int JB_CELL_US         = 4;
  localparam int JB_ONE_LOW_US      = 1;
  localparam int JB_ZERO_LOW_US     = 3;
  localparam int JB_STOP_CONSOLE_US = 1;
  localparam int JB_STOP_CTRL_US    = 2;

  // Longest frame the receiver accepts, in bytes
  localparam int JB_MAX_FRAME_BYTES = 63;

  // Receiver states
  typedef enum logic [1:0] {
    RX_ARM,
    RX_IDLE,
    RX_LOW,
    RX_HIGH
  } rx_state_t;

  // Convert a duration in microseconds into clock cycles
  function automatic int jb_us_to_cyc(input int us, input int clk_per_us);
    return us * clk_per_us;
  endfunction

endpackage

// File: rtl/jb_sync.sv
// Two-flop synchronizer for the open-drain Joybus line with edge detection.
// All flops reset high, matching an idle (pulled-up) line.
module jb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic fall,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync = r_sync;
  assign fall = r_prev & ~r_sync;
  assign rise = ~r_prev & r_sync;

endmodule

// File: rtl/joybus_rx.sv
// Joybus line receiver: decodes bit cells by low-phase length, packs them
// MSB-first into bytes and closes the frame after an idle-high interval.
module joybus_rx
  import jb_pkg::*;
#(
  parameter int CLK_PER_US  = JB_CLK_PER_US,
  parameter int THRESH_CYC  = 2 * CLK_PER_US,
  parameter int GLITCH_CYC  = JB_GLITCH_CYC,
  parameter int LOW_MAX_CYC = 4 * CLK_PER_US,
  parameter int IDLE_CYC    = 5 * CLK_PER_US
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jb_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [5:0] rx_len,
  output logic       busy
);

  localparam int LOW_W  = $clog2(LOW_MAX_CYC + 1);
  localparam int HIGH_W = $clog2(IDLE_CYC + 1);

  localparam logic [LOW_W-1:0]  THRESH_L  = LOW_W'(THRESH_CYC);
  localparam logic [LOW_W-1:0]  GLITCH_L  = LOW_W'(GLITCH_CYC);
  localparam logic [LOW_W-1:0]  LOW_MAX_L = LOW_W'(LOW_MAX_CYC);
  localparam logic [LOW_W-1:0]  LOW_ONE   = LOW_W'(1);
  localparam logic [HIGH_W-1:0] IDLE_H    = HIGH_W'(IDLE_CYC);
  localparam logic [HIGH_W-1:0] HIGH_ONE  = HIGH_W'(1);
  localparam logic [5:0]        LEN_MAX   = 6'(JB_MAX_FRAME_BYTES);

  logic w_sync;
  logic w_fall;
  logic w_rise;

  jb_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (jb_rx),
    .sync  (w_sync),
    .fall  (w_fall),
    .rise  (w_rise)
  );

  rx_state_t         r_state;
  logic [LOW_W-1:0]  r_low_cnt;
  logic [HIGH_W-1:0] r_high_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_byte;
  logic [5:0]        r_len;
  logic              r_valid;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  rx_state_t         w_state_next;
  logic [LOW_W-1:0]  w_low_next;
  logic [HIGH_W-1:0] w_high_next;
  logic [2:0]        w_bit_next;
  logic [7:0]        w_shift_next;
  logic [7:0]        w_byte_next;
  logic [5:0]        w_len_next;
  logic              w_valid_next;
  logic              w_done_next;
  logic              w_err_next;
  logic              w_busy_next;
  logic              w_cell_bit;
  logic [7:0]        w_shifted;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RX_ARM;
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_len      <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_low_cnt  <= w_low_next;
      r_high_cnt <= w_high_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_byte     <= w_byte_next;
      r_len      <= w_len_next;
      r_valid    <= w_valid_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_busy     <= w_busy_next;
    end
  end

  // Next-state, counter and strobe logic
  always_comb begin
    w_state_next = r_state;
    w_low_next   = r_low_cnt;
    w_high_next  = r_high_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_byte_next  = r_byte;
    w_len_next   = r_len;
    w_valid_next = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_cell_bit   = (r_low_cnt < THRESH_L);
    w_shifted    = {r_shift[6:0], w_cell_bit};

    unique case (r_state)
      // Only leave once the line has been continuously high for the idle time,
      // so a frame caught halfway (after reset or an error) is never decoded.
      RX_ARM: begin
        if (!w_sync) begin
          w_high_next = '0;
        end else if (r_high_cnt >= IDLE_H) begin
          w_state_next = RX_IDLE;
        end else begin
          w_high_next = r_high_cnt + 1'b1;
        end
      end

      // Frame start. The falling-edge cycle is itself the first low cycle,
      // so low_cnt starts at 1 and equals the low-phase length at the rise.
      RX_IDLE: begin
        if (w_fall) begin
          w_low_next   = LOW_ONE;
          w_bit_next   = '0;
          w_len_next   = '0;
          w_state_next = RX_LOW;
        end
      end

      // Measure the low phase; a rise decides the bit, a timeout is a fault.
      RX_LOW: begin
        if (w_rise) begin
          if (r_low_cnt < GLITCH_L) begin
            w_err_next   = 1'b1;
            w_high_next  = '0;
            w_state_next = RX_ARM;
          end else if (r_bit_cnt == 3'd7) begin
            if (r_len == LEN_MAX) begin
              // No room for another byte: abort without touching rx_byte
              w_err_next   = 1'b1;
              w_high_next  = '0;
              w_state_next = RX_ARM;
            end else begin
              w_shift_next = w_shifted;
              w_byte_next  = w_shifted;
              w_valid_next = 1'b1;
              w_len_next   = r_len + 6'd1;
              w_bit_next   = '0;
              w_high_next  = HIGH_ONE;
              w_state_next = RX_HIGH;
            end
          end else begin
            w_shift_next = w_shifted;
            w_bit_next   = r_bit_cnt + 3'd1;
            w_high_next  = HIGH_ONE;
            w_state_next = RX_HIGH;
          end
        end else if (r_low_cnt >= LOW_MAX_L) begin
          w_err_next   = 1'b1;
          w_high_next  = '0;
          w_state_next = RX_ARM;
        end else begin
          w_low_next = r_low_cnt + 1'b1;
        end
      end

      // Measure the high phase; a long enough high closes the frame.
      // A clean frame ends right after its stop bit, leaving exactly one bit.
      RX_HIGH: begin
        if (w_fall) begin
          w_low_next   = LOW_ONE;
          w_state_next = RX_LOW;
        end else if (r_high_cnt >= IDLE_H) begin
          if ((r_bit_cnt == 3'd1) && (r_len != 6'd0)) begin
            w_done_next = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
          w_state_next = RX_IDLE;
        end else begin
          w_high_next = r_high_cnt + 1'b1;
        end
      end

      default: w_state_next = RX_ARM;
    endcase

    w_busy_next = (w_state_next == RX_LOW) || (w_state_next == RX_HIGH);
  end

  assign rx_byte    = r_byte;
  assign rx_valid   = r_valid;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign rx_len     = r_len;
  assign busy       = r_busy;

endmodule

// File: tb/tb_joybus_rx.sv
// Self-checking bench for joybus_rx: scenario tasks with randomized frames
// compared against a bit-cell level reference model.
`timescale 1ns/1ps
module tb_joybus_rx;

  localparam int CLK_PER_US  = 50;
  localparam int THRESH_CYC  = 100;
  localparam int GLITCH_CYC  = 5;
  localparam int LOW_MAX_CYC = 200;
  localparam int IDLE_CYC    = 250;

  logic       clk;
  logic       rst_n;
  logic       jb_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_done;
  logic       frame_err;
  logic [5:0] rx_len;
  logic       busy;

  joybus_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jb_rx      (jb_rx),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .rx_len     (rx_len),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Observed events
  logic [7:0] got_bytes[$];
  int got_done, got_err, got_len, got_both, busy_seen;

  // Stimulus description: per bit cell, its low and following high length
  int lows[$];
  int highs[$];

  // Model expectations
  logic [7:0] exp_bytes[$];
  int exp_done, exp_err, exp_len;

  always @(posedge clk) begin
    #1;
    if (rx_valid) got_bytes.push_back(rx_byte);
    if (frame_done) begin got_done++; got_len = int'(rx_len); end
    if (frame_err) got_err++;
    if (rx_valid && frame_err) got_both++;
    if (busy) busy_seen = 1;
  end

  task automatic clear_mon();
    got_bytes.delete();
    got_done = 0; got_err = 0; got_len = 0; got_both = 0; busy_seen = 0;
  endtask

  task automatic drive_cell(input int lo, input int hi);
    jb_rx = 1'b0;
    repeat (lo) @(negedge clk);
    jb_rx = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic play_frame();
    @(negedge clk);
    clear_mon();
    for (int i = 0; i < lows.size(); i++) drive_cell(lows[i], highs[i]);
    repeat (IDLE_CYC + 40) @(negedge clk);
  endtask

  function automatic void add_nominal_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      lows.push_back(b[k] ? 50 : 150);
      highs.push_back(b[k] ? 150 : 50);
    end
  endfunction

  function automatic void build_random(input int nbytes);
    logic [7:0] b;
    lows.delete(); highs.delete();
    for (int n = 0; n < nbytes; n++) begin
      b = 8'($urandom);
      for (int k = 7; k >= 0; k--) begin
        lows.push_back(b[k] ? int'($urandom_range(90, 10)) : int'($urandom_range(195, 105)));
        highs.push_back(int'($urandom_range(100, 20)));
      end
    end
    lows.push_back(($urandom_range(1, 0) == 1) ? 50 : 100);
    highs.push_back(0);
  endfunction

  // Reference: a low phase shorter than the threshold is a 1, eight bits form
  // a byte, a glitch/overlong low or 64th byte aborts, and a clean frame is
  // whole bytes followed by exactly one stop bit.
  function automatic void model_frame();
    int nbits, nbytes, acc, aborted;
    nbits = 0; nbytes = 0; acc = 0; aborted = 0;
    exp_bytes.delete();
    for (int i = 0; i < lows.size() && aborted == 0; i++) begin
      if (lows[i] < GLITCH_CYC || lows[i] > LOW_MAX_CYC) begin
        aborted = 1;
      end else begin
        acc = (acc * 2 + ((lows[i] < THRESH_CYC) ? 1 : 0)) % 256;
        nbits++;
        if (nbits == 8) begin
          if (nbytes == 63) aborted = 1;
          else begin exp_bytes.push_back(8'(acc)); nbytes++; nbits = 0; acc = 0; end
        end
      end
    end
    exp_len  = nbytes;
    exp_done = (aborted == 0 && nbits == 1 && nbytes >= 1) ? 1 : 0;
    exp_err  = 1 - exp_done;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; jb_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else pass_cnt++;
    chk_cnt++; if (rx_len !== 6'd0) $display("FAIL reset_rx_len got=%0d exp=0", rx_len); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    rst_n = 1'b1;
    repeat (IDLE_CYC + 20) @(negedge clk);
    $display("reset: released, receiver armed");
  endtask

  task automatic test_command();
    logic [7:0] want[3];
    want[0] = 8'h40; want[1] = 8'h03; want[2] = 8'h00;
    lows.delete(); highs.delete();
    for (int n = 0; n < 3; n++) add_nominal_byte(want[n]);
    lows.push_back(50); highs.push_back(0);
    play_frame();
    chk_cnt++; if (got_bytes.size() != 3) $display("FAIL cmd_nbytes got=%0d exp=3", got_bytes.size()); else pass_cnt++;
    for (int n = 0; n < 3; n++) begin
      chk_cnt++;
      if (n >= got_bytes.size() || got_bytes[n] !== want[n]) $display("FAIL cmd_byte%0d got=%h exp=%h", n, (n < got_bytes.size()) ? got_bytes[n] : 8'hxx, want[n]);
      else pass_cnt++;
    end
    chk_cnt++; if (got_done != 1) $display("FAIL cmd_done got=%0d exp=1", got_done); else pass_cnt++;
    chk_cnt++; if (got_err != 0) $display("FAIL cmd_err got=%0d exp=0", got_err); else pass_cnt++;
    chk_cnt++; if (got_len != 3) $display("FAIL cmd_len got=%0d exp=3", got_len); else pass_cnt++;
    chk_cnt++; if (rx_len !== 6'd3) $display("FAIL cmd_len_held got=%0d exp=3", rx_len); else pass_cnt++;
    chk_cnt++; if (busy_seen != 1) $display("FAIL cmd_busy_seen got=%0d exp=1", busy_seen); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL cmd_busy_end got=%b exp=0", busy); else pass_cnt++;
    $display("command: bytes=%0d done=%0d len=%0d", got_bytes.size(), got_done, got_len);
  endtask

  task automatic test_controller();
    lows.delete(); highs.delete();
    add_nominal_byte(8'h80);
    lows.push_back(100); highs.push_back(0);
    play_frame();
    chk_cnt++; if (got_bytes.size() != 1 || got_bytes[0] !== 8'h80) $display("FAIL ctrl_byte got_n=%0d got=%h exp=80", got_bytes.size(), rx_byte); else pass_cnt++;
    chk_cnt++; if (got_done != 1 || got_err != 0) $display("FAIL ctrl_done got done=%0d err=%0d exp done=1 err=0", got_done, got_err); else pass_cnt++;
    chk_cnt++; if (got_len != 1) $display("FAIL ctrl_len got=%0d exp=1", got_len); else pass_cnt++;
    $display("controller: byte=%h done=%0d", rx_byte, got_done);
  endtask

  task automatic test_threshold();
    logic [7:0] b;
    b = 8'hA5;
    lows.delete(); highs.delete();
    for (int k = 7; k >= 0; k--) begin
      lows.push_back(b[k] ? 95 : 100);
      highs.push_back(100);
    end
    lows.push_back(50); highs.push_back(0);
    play_frame();
    chk_cnt++; if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5) $display("FAIL thresh_byte got_n=%0d got=%h exp=a5", got_bytes.size(), rx_byte); else pass_cnt++;
    chk_cnt++; if (got_done != 1) $display("FAIL thresh_done got=%0d exp=1", got_done); else pass_cnt++;
    $display("threshold: byte=%h", rx_byte);
  endtask

  task automatic test_latency();
    logic [7:0] b;
    int lat;
    b = 8'($urandom);
    @(negedge clk);
    clear_mon();
    for (int k = 7; k >= 1; k--) drive_cell(b[k] ? 50 : 150, b[k] ? 150 : 50);
    jb_rx = 1'b0;
    repeat (b[0] ? 50 : 150) @(negedge clk);
    jb_rx = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rx_valid && lat == 0) lat = k;
    end
    @(negedge clk);
    repeat (40) @(negedge clk);
    drive_cell(50, IDLE_CYC + 40);
    chk_cnt++; if (lat != 3) $display("FAIL latency_valid got=%0d exp=3", lat); else pass_cnt++;
    chk_cnt++; if (got_bytes.size() != 1 || got_bytes[0] !== b) $display("FAIL latency_byte got=%h exp=%h", rx_byte, b); else pass_cnt++;
    chk_cnt++; if (got_done != 1) $display("FAIL latency_done got=%0d exp=1", got_done); else pass_cnt++;
    $display("latency: byte=%h cycles=%0d", b, lat);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      build_random(int'($urandom_range(3, 1)));
      model_frame();
      play_frame();
      chk_cnt++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL rand%0d_nbytes got=%0d exp=%0d", f, got_bytes.size(), exp_bytes.size()); else pass_cnt++;
      for (int n = 0; n < exp_bytes.size(); n++) begin
        chk_cnt++;
        if (n >= got_bytes.size() || got_bytes[n] !== exp_bytes[n]) $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, n, (n < got_bytes.size()) ? got_bytes[n] : 8'hxx, exp_bytes[n]);
        else pass_cnt++;
      end
      chk_cnt++; if (got_done != exp_done || got_err != exp_err) $display("FAIL rand%0d_end got done=%0d err=%0d exp done=%0d err=%0d", f, got_done, got_err, exp_done, exp_err); else pass_cnt++;
      chk_cnt++; if (got_len != exp_len) $display("FAIL rand%0d_len got=%0d exp=%0d", f, got_len, exp_len); else pass_cnt++;
      chk_cnt++; if (got_both != 0) $display("FAIL rand%0d_valid_err_overlap got=%0d exp=0", f, got_both); else pass_cnt++;
      $display("random frame %0d: bytes=%0d done=%0d len=%0d", f, got_bytes.size(), got_done, got_len);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    clear_mon();
    for (int k = 0; k < 3; k++) drive_cell(50, 150);
    drive_cell(3, IDLE_CYC + 60);
    chk_cnt++; if (got_err != 1) $display("FAIL glitch_err got=%0d exp=1", got_err); else pass_cnt++;
    chk_cnt++; if (got_bytes.size() != 0 || got_done != 0) $display("FAIL glitch_quiet got bytes=%0d done=%0d exp 0/0", got_bytes.size(), got_done); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", busy); else pass_cnt++;
    build_random(2);
    model_frame();
    play_frame();
    chk_cnt++; if (got_bytes.size() != 2 || got_bytes[0] !== exp_bytes[0] || got_bytes[1] !== exp_bytes[1]) $display("FAIL glitch_next_bytes got_n=%0d last=%h exp=%h %h", got_bytes.size(), rx_byte, exp_bytes[0], exp_bytes[1]); else pass_cnt++;
    chk_cnt++; if (got_done != 1) $display("FAIL glitch_next_done got=%0d exp=1", got_done); else pass_cnt++;
    $display("glitch: recovered frame bytes=%0d", got_bytes.size());
  endtask

  task automatic test_stuck_low();
    int t;
    @(negedge clk);
    clear_mon();
    jb_rx = 1'b0;
    t = 0;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk); #1;
      if (frame_err && t == 0) t = k;
    end
    @(negedge clk);
    jb_rx = 1'b1;
    repeat (IDLE_CYC + 40) @(negedge clk);
    chk_cnt++; if (t != LOW_MAX_CYC + 3) $display("FAIL stuck_err_time got=%0d exp=%0d", t, LOW_MAX_CYC + 3); else pass_cnt++;
    chk_cnt++; if (got_err != 1 || got_done != 0) $display("FAIL stuck_events got err=%0d done=%0d exp err=1 done=0", got_err, got_done); else pass_cnt++;
    $display("stuck low: frame_err after %0d cycles", t);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int k = 0; k < 4; k++) drive_cell(150, 50);
    jb_rx = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (rx_byte !== 8'h00 || rx_len !== 6'd0) $display("FAIL rstmid_data got byte=%h len=%0d exp 00/0", rx_byte, rx_len); else pass_cnt++;
    chk_cnt++; if ({rx_valid, frame_done, frame_err, busy} !== 4'b0000) $display("FAIL rstmid_flags got=%b exp=0000", {rx_valid, frame_done, frame_err, busy}); else pass_cnt++;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    for (int k = 0; k < 12; k++) drive_cell(int'($urandom_range(150, 10)), int'($urandom_range(150, 20)));
    repeat (IDLE_CYC + 40) @(negedge clk);
    chk_cnt++; if (got_bytes.size() != 0 || got_done != 0 || got_err != 0) $display("FAIL rstmid_quiet got bytes=%0d done=%0d err=%0d exp 0/0/0", got_bytes.size(), got_done, got_err); else pass_cnt++;
    build_random(1);
    model_frame();
    play_frame();
    chk_cnt++; if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0]) $display("FAIL rstmid_next_byte got=%h exp=%h", rx_byte, exp_bytes[0]); else pass_cnt++;
    chk_cnt++; if (got_done != 1 || got_len != 1) $display("FAIL rstmid_next_done got done=%0d len=%0d exp 1/1", got_done, got_len); else pass_cnt++;
    $display("reset mid-frame: next byte=%h", rx_byte);
  endtask

  task automatic test_overflow();
    lows.delete(); highs.delete();
    for (int n = 0; n < 64 * 8; n++) begin lows.push_back(10); highs.push_back(10); end
    lows.push_back(50); highs.push_back(0);
    model_frame();
    play_frame();
    chk_cnt++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL ovf_nbytes got=%0d exp=%0d", got_bytes.size(), exp_bytes.size()); else pass_cnt++;
    chk_cnt++; if (got_err != exp_err || got_done != exp_done) $display("FAIL ovf_end got err=%0d done=%0d exp err=%0d done=%0d", got_err, got_done, exp_err, exp_done); else pass_cnt++;
    chk_cnt++; if (int'(rx_len) != exp_len) $display("FAIL ovf_len got=%0d exp=%0d", rx_len, exp_len); else pass_cnt++;
    chk_cnt++; if (got_both != 0) $display("FAIL ovf_valid_err_overlap got=%0d exp=0", got_both); else pass_cnt++;
    $display("overflow: bytes=%0d err=%0d len=%0d", got_bytes.size(), got_err, rx_len);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_command();
    test_controller();
    test_threshold();
    test_latency();
    test_random();
    test_glitch();
    test_stuck_low();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
